fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS core, directly downstream of the PC unit. Drives the instruction-memory request from the current PC, generates `pcenable` to advance or redirect the PC, and owns the IF/ID pipeline register feeding decode. Handles decode stalls, redirect flushes with a non-abortable memory request in flight, and halt.

## Interface
Parameters:
- `RESET_PC4`, default `32'h0000_0004`: IF/ID `ifid_pc4` value during and after reset.

Ports:
- `CLK`  in  1  clock; all state on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `pcout`  in  32  current PC from the PC unit.
- `pcenable`  out  1  PC load enable to the PC unit (combinational).
- `imemREN`  out  1  instruction read request.
- `imemaddr`  out  32  instruction address.
- `ihit`  in  1  memory returns `imemload` this cycle for `imemaddr`.
- `imemload`  in  32  instruction data.
- `stall`  in  1  decode cannot accept; IF/ID must hold.
- `flush`  in  1  redirect resolved (pcsrc != 00 taken); squash IF/ID, load PC target.
- `halt`  in  1  halt decoded; stop fetching.
- `ifid_valid`  out  1  IF/ID holds a live instruction.
- `ifid_instr`  out  32  fetched instruction.
- `ifid_pc4`  out  32  fetch PC + 4 (consumed as `branch_pc4`).
- `fetch_count`, `stall_count`  out  32 each  perf counters (only with `FETCH_PERF_EN`).

## Operation
- States: `FETCH`, `DRAIN`, `HALTED`. Reset → `FETCH`.
- `FETCH`: `imemREN`=1, `imemaddr`=`pcout`; `req_addr` register ← `pcout` every cycle.
  - `ihit & !stall & !flush`: `pcenable`=1; IF/ID ← {1, `imemload`, `pcout`+4}.
  - `ihit & stall & !flush`: `pcenable`=0; IF/ID holds; data discarded, same address refetched.
  - `!ihit & !flush`: `pcenable`=0; IF/ID holds if `stall`, else `ifid_valid`←0 (bubble).
  - `flush & ihit`: `pcenable`=1; data discarded; `ifid_valid`←0; stay `FETCH`.
  - `flush & !ihit`: `pcenable`=1; `ifid_valid`←0; → `DRAIN`.
  - `halt` (and no `flush`): `pcenable`=0; `ifid_valid`←0; → `HALTED`.
- `DRAIN`: `imemREN`=1, `imemaddr`=`req_addr` (held); `pcenable`=`flush`; `ifid_valid`←0. On `ihit`: data discarded, → `FETCH`.
- `HALTED`: `imemREN`=0, `pcenable`=0, `ifid_valid`=0; exits only on `RST`.
- Priority: `RST` > `flush` > `halt` > `stall`.
- `pcout`+4 wraps modulo 2^32.

## Timing
- Reset values (registers, next edge after `RST` high): `ifid_valid`=0, `ifid_instr`=0, `ifid_pc4`=`RESET_PC4`, counters=0. While `RST`=1: `imemREN`=0, `pcenable`=0.
- Latency: `ihit` in cycle N → IF/ID valid in cycle N+1. Sustained 1 instr/cycle with `ihit` every cycle and no stall.
- `pcenable` combinational from `ihit`/`stall`/`flush`/state; PC updates at the same edge as IF/ID.
- Request held stable (`imemaddr` constant, `imemREN`=1) from issue until `ihit`; memory request is never withdrawn.
- `RST` mid-`DRAIN`: returns to `FETCH` immediately; the outstanding request is abandoned (memory also reset).

## Configuration
- `FETCH_PERF_EN` defined: `fetch_count` increments on each IF/ID load with `ifid_valid`←1; `stall_count` increments each cycle `stall`=1 and state ≠ `HALTED`; both wrap at 2^32, clear on `RST`.
- Undefined: counter ports and logic absent.

## Structure
- `cpu_types_pkg`: `word_t` (existing); add `fetch_state_t` enum {`FETCH`, `DRAIN`, `HALTED`} and `ifid_t` struct {valid, instr, pc4}.
- Sub-module `ifid_reg`: IF/ID register with load/hold/squash controls; FSM and perf counters stay in `fetch_stage`.

## Test plan
- Reset, then `ihit`=1 every cycle, `pcout` 0,4,8 → `ifid_pc4` 4,8,12 on consecutive cycles, `pcenable`=1 each cycle.
- `stall`=1 for 3 cycles with `ihit`=1, `pcout`=0x40 → `pcenable`=0, IF/ID unchanged, `imemaddr`=0x40 throughout.
- `flush`=1 with `ihit`=0, `pcout`=0x80 → `pcenable`=1 that cycle; next cycles `imemaddr`=0x80 until `ihit`, data dropped, `ifid_valid`=0; then fetch from new `pcout`.
- `flush` and `halt` same cycle → flush taken, state ≠ `HALTED`; later `halt` alone → `imemREN`=0 permanently until `RST`.
- `pcout`=0xFFFF_FFFC with `ihit` → `ifid_pc4`=0x0000_0000.
- With `FETCH_PERF_EN`: 10 hits, 4 stall cycles → `fetch_count`=10, `stall_count`=4; `RST` → both 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS pipeline front end: machine word, fetch FSM states
// and the IF/ID pipeline register layout.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic  valid;
        word_t instr;
        word_t pc4;
    } ifid_t;

    localparam word_t PC_STEP = 32'd4;

    // Sequential PC of a fetched instruction; wraps modulo 2^32.
    function automatic word_t next_pc4(input word_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Load has priority over squash; squash clears only
// the valid bit, otherwise the contents hold.
module ifid_reg
    import cpu_types_pkg::*;
#(
    parameter word_t RESET_PC4 = 32'h0000_0004
) (
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_load,
    input  logic  i_squash,
    input  word_t i_instr,
    input  word_t i_pc4,
    output ifid_t o_ifid
);

    ifid_t r_ifid;

    // Pipeline register update: reset, load, squash or hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ifid.valid <= 1'b0;
            r_ifid.instr <= 32'd0;
            r_ifid.pc4   <= RESET_PC4;
        end else if (i_load) begin
            r_ifid.valid <= 1'b1;
            r_ifid.instr <= i_instr;
            r_ifid.pc4   <= i_pc4;
        end else if (i_squash) begin
            r_ifid.valid <= 1'b0;
        end else begin
            r_ifid <= r_ifid;
        end
    end

    assign o_ifid = r_ifid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: memory request, PC enable, redirect drain and halt.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t RESET_PC4 = 32'h0000_0004
) (
    input  logic  CLK,
    input  logic  RST,
    input  word_t pcout,
    output logic  pcenable,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  ihit,
    input  word_t imemload,
    input  logic  stall,
    input  logic  flush,
    input  logic  halt,
    output logic  ifid_valid,
    output word_t ifid_instr,
    output word_t ifid_pc4
`ifdef FETCH_PERF_EN
    ,
    output word_t fetch_count,
    output word_t stall_count
`endif
);

    fetch_state_t r_state;
    word_t        r_req_addr;
    logic         w_pcenable;
    logic         w_imemren;
    word_t        w_imemaddr;
    logic         w_load;
    logic         w_squash;
    ifid_t        w_ifid;

    // Request, PC enable and IF/ID control decode; priority flush > halt > stall.
    always_comb begin
        w_pcenable = 1'b0;
        w_imemren  = 1'b0;
        w_imemaddr = pcout;
        w_load     = 1'b0;
        w_squash   = 1'b0;
        if (RST) begin
            w_pcenable = 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    w_imemren  = 1'b1;
                    w_imemaddr = pcout;
                    if (flush) begin
                        w_pcenable = 1'b1;
                        w_squash   = 1'b1;
                    end else if (halt) begin
                        w_squash = 1'b1;
                    end else if (ihit && !stall) begin
                        w_pcenable = 1'b1;
                        w_load     = 1'b1;
                    end else if (!ihit && !stall) begin
                        w_squash = 1'b1;
                    end else begin
                        w_squash = 1'b0;
                    end
                end
                DRAIN: begin
                    // The squashed request cannot be withdrawn; keep it on the bus.
                    w_imemren  = 1'b1;
                    w_imemaddr = r_req_addr;
                    w_pcenable = flush;
                    w_squash   = 1'b1;
                end
                HALTED: begin
                    w_squash = 1'b1;
                end
                default: begin
                    w_squash = 1'b1;
                end
            endcase
        end
    end

    // Fetch FSM and in-flight request address.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= FETCH;
            r_req_addr <= 32'd0;
        end else begin
            case (r_state)
                FETCH: begin
                    r_req_addr <= pcout;
                    if (flush) begin
                        r_state <= ihit ? FETCH : DRAIN;
                    end else if (halt) begin
                        r_state <= HALTED;
                    end else begin
                        r_state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (ihit) begin
                        r_state <= FETCH;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    ifid_reg #(
        .RESET_PC4 (RESET_PC4)
    ) u_ifid_reg (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_load   (w_load),
        .i_squash (w_squash),
        .i_instr  (imemload),
        .i_pc4    (next_pc4(pcout)),
        .o_ifid   (w_ifid)
    );

    assign pcenable   = w_pcenable;
    assign imemREN    = w_imemren;
    assign imemaddr   = w_imemaddr;
    assign ifid_valid = w_ifid.valid;
    assign ifid_instr = w_ifid.instr;
    assign ifid_pc4   = w_ifid.pc4;

`ifdef FETCH_PERF_EN
    word_t r_fetch_count;
    word_t r_stall_count;

    // Performance counters; both wrap naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (w_load) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (stall && (r_state != HALTED)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural PC/memory/pipeline model
// queues expectations, a negedge monitor compares them against the DUT.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC4 = 32'h0000_0004;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] pcout = 32'd0;
    logic        pcenable;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit = 1'b0;
    logic [31:0] imemload = 32'd0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        halt = 1'b0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    fetch_stage #(.RESET_PC4(RST_PC4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .pcout      (pcout),
        .pcenable   (pcenable),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .stall      (stall),
        .flush      (flush),
        .halt       (halt),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count(fetch_count),
        .stall_count(stall_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic        ren;
        logic        chk_addr;
        logic [31:0] addr;
    } comb_t;

    typedef struct {
        int          tag;
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] fc;
        logic [31:0] sc;
    } reg_t;

    comb_t comb_q[$];
    reg_t  reg_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;

    // Behavioural model state: PC unit, pending drain address, IF/ID contents.
    bit          m_drain = 1'b0;
    bit          m_halt = 1'b0;
    logic [31:0] m_pend = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        m_v = 1'b0;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_pc4 = 32'd0;
    logic [31:0] m_fc = 32'd0;
    logic [31:0] m_sc = 32'd0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock of stimulus plus the model's expectations for it.
    task automatic step(input bit rst, input bit ih, input bit st, input bit fl,
                        input bit hl, input bit setpc, input logic [31:0] pcv);
        comb_t       c;
        reg_t        r;
        logic [31:0] tgt;
        bit          en;
        @(posedge CLK);
        #1;
        if (setpc) pc = pcv;
        tgt        = $urandom & 32'hFFFF_FFFC;
        c.ren      = !rst && !m_halt;
        c.chk_addr = c.ren;
        c.addr     = m_drain ? m_pend : pc;
        if (!c.ren) ih = 1'b0;
        en = 1'b0;
        if (!rst && !m_halt) en = m_drain ? fl : (fl || (ih && !st && !hl));
        c.en = en;
        RST = rst; ihit = ih; stall = st; flush = fl; halt = hl; pcout = pc;
        imemload = ih ? mem_word(c.addr) : $urandom;
        comb_q.push_back(c);
        if (rst) begin
            m_v = 1'b0; m_instr = 32'd0; m_pc4 = RST_PC4;
            m_drain = 1'b0; m_halt = 1'b0; m_fc = 32'd0; m_sc = 32'd0; pc = 32'd0;
        end else begin
            if (st && !m_halt) m_sc = m_sc + 32'd1;
            if (m_halt) begin
                m_v = 1'b0;
            end else if (m_drain) begin
                m_v = 1'b0;
                if (ih) m_drain = 1'b0;
            end else if (fl) begin
                m_v = 1'b0;
                if (!ih) begin
                    m_drain = 1'b1;
                    m_pend  = pc;
                end
            end else if (hl) begin
                m_v = 1'b0;
                m_halt = 1'b1;
            end else if (ih && !st) begin
                m_v = 1'b1; m_instr = mem_word(pc); m_pc4 = pc + 32'd4;
                m_fc = m_fc + 32'd1;
            end else if (!st) begin
                m_v = 1'b0;
            end
            if (en) pc = fl ? tgt : pc + 32'd4;
        end
        r.tag = cyc + 1; r.v = m_v; r.instr = m_instr; r.pc4 = m_pc4;
        r.fc = m_fc; r.sc = m_sc;
        reg_q.push_back(r);
    endtask

    comb_t mc;
    reg_t  mr;

    // Monitor: combinational outputs for this cycle, registers after the last edge.
    always @(negedge CLK) begin
        if (comb_q.size() > 0) begin
            mc = comb_q.pop_front();
            chk("pcenable", {31'd0, pcenable}, {31'd0, mc.en});
            chk("imemREN", {31'd0, imemREN}, {31'd0, mc.ren});
            if (mc.chk_addr) chk("imemaddr", imemaddr, mc.addr);
        end
        while (reg_q.size() > 0 && reg_q[0].tag == cyc) begin
            mr = reg_q.pop_front();
            chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, mr.v});
            chk("ifid_instr", ifid_instr, mr.instr);
            chk("ifid_pc4", ifid_pc4, mr.pc4);
`ifdef FETCH_PERF_EN
            chk("fetch_count", fetch_count, mr.fc);
            chk("stall_count", stall_count, mr.sc);
`endif
        end
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          rr, ih, st, fl, hl, sp;
        logic [31:0] pv;
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        // Back-to-back hits from PC 0.
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        // Decode stall with hits at 0x40.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        // Redirect while the 0x80 request is still outstanding.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        // Flush beats halt, then halt alone.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        // PC+4 wrap.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        // Ten hits then four stall cycles, then reset.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            rr = ($urandom_range(0, 119) == 0);
            ih = ($urandom_range(0, 9) < 6);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            hl = ($urandom_range(0, 149) == 0);
            sp = ($urandom_range(0, 39) == 0);
            pv = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            step(rr, ih, st, fl, hl, sp, pv);
        end
        @(posedge CLK);
        @(negedge CLK);
        #1;
        tests++;
        if (comb_q.size() != 0 || reg_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0",
                     comb_q.size(), reg_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
